decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 No parameters; datapath fixed at 32 bits, register file at 32 x 32.
REQ-002 CLK  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 InstrD  in  32  instruction from IF/ID register.
REQ-005 PCPlus4D  in  32  PC+4 of InstrD.
REQ-006 RegWriteW, WriteRegW[4:0], ResultW[31:0]  in  writeback port.
REQ-007 ForwardAD, ForwardBD  in  1 each  select ALUOutM for branch compare A/B.
REQ-008 ALUOutM  in  32  memory-stage ALU result.
REQ-009 RD1D, RD2D  out  32 each  register reads of Rs/Rt, to ID/EX register.
REQ-010 SignImmD  out  32  sign-extended InstrD[15:0].
REQ-011 RsD, RtD, RdD  out  5 each  InstrD[25:21], [20:16], [15:11].
REQ-012 RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, BranchD, JumpD  out  1 each  decoded controls.
REQ-013 ALUControlD  out  3  ALU operation.
REQ-014 PCSrcD  out  1  branch taken; PCBranchD  out  32  branch target; PCJumpD  out  32  jump target.

Function
REQ-015 Register file: 32 x 32-bit; register 0 reads 0 and ignores writes.
REQ-016 Write on rising CLK when RegWriteW=1 and WriteRegW!=0.
REQ-017 Reads combinational; when RegWriteW=1, WriteRegW!=0 and WriteRegW equals the read address, the read returns ResultW in the same cycle (write-through).
REQ-018 SignImmD = {16{InstrD[15]}, InstrD[15:0]}.
REQ-019 Decode by opcode InstrD[31:26] (RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, Jump, ALUControl):
- 000000 R-type: 1,1,0,0,0,0,0, from funct.
- 100011 lw: 1,0,1,0,0,1,0,010.
- 101011 sw: 0,0,1,0,1,0,0,010.
- 000100 beq: 0,0,0,1,0,0,0,110.
- 001000 addi: 1,0,1,0,0,0,0,010.
- 000010 j: 0,0,0,0,0,0,1,000.
REQ-020 R-type funct InstrD[5:0] -> ALUControlD:
- 100000 -> 010
- 100010 -> 110
- 100100 -> 000
- 100101 -> 001
- 101010 -> 111
REQ-021 Unknown opcode -> all controls 0 (NOP); unknown funct with R-type -> ALUControlD=000 and RegWriteD=0.
REQ-022 Compare operands: A = ForwardAD ? ALUOutM : RD1D; B = ForwardBD ? ALUOutM : RD2D.
REQ-023 PCSrcD = BranchD & (A==B).
REQ-024 Branch target: PCBranchD = PCPlus4D + (SignImmD<<2), modulo 2^32.
REQ-025 Jump target: PCJumpD = {PCPlus4D[31:28], InstrD[25:0], 2'b00}.
REQ-026 RD1D/RD2D are never forwarded from ALUOutM; the forwarding muxes feed only the comparator.
REQ-027 Simultaneous write and read of the same register in one cycle obeys REQ-017.
REQ-027a A write to register 0 leaves it reading 0.

Reset
REQ-028 rst=0 asynchronously clears all 32 registers to 0, independent of CLK.
REQ-029 Write attempts while rst=0 are ignored.
REQ-030 All outputs are combinational functions of inputs and register state; with InstrD=0 after reset, outputs are 0 except R-type controls RegWriteD=0 (funct 000000 unknown) and RegDstD=1.
REQ-031 Reset asserted mid-write cancels the write.

Verification
REQ-032 Reset, then read all 32 registers -> each reads 0.
REQ-033 Write R5=0x12345678, then add $3,$5,$5 -> RD1D=RD2D=0x12345678, RegWriteD=1, RegDstD=1, ALUControlD=010.
REQ-034 Write attempt to R0 with 0xFFFFFFFF -> RD1D for Rs=0 reads 0.
REQ-035 Same cycle: RegWriteW=1, WriteRegW=7, ResultW=0xA5A5A5A5, Rs=7 -> RD1D=0xA5A5A5A5 before the clock edge.
REQ-036 beq with R1=R2=4, imm=0xFFFF, PCPlus4D=0x100 -> PCSrcD=1, PCBranchD=0xFC; repeat with ForwardAD=1, ALUOutM=5 -> PCSrcD=0.
REQ-037 j with InstrD[25:0]=0x0000010, PCPlus4D=0x40000004 -> JumpD=1, PCJumpD=0x40000040; opcode 111111 -> all controls 0.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage -- instruction decode stage of a 5-stage MIPS-style pipeline.
//
// Holds the 32 x 32 register file with a write-through bypass, decodes the
// opcode/funct into datapath controls, sign-extends the immediate and resolves
// branches early: equality compare with optional forwarding from the memory
// stage, plus branch and jump target generation.
//
// Ports
//   CLK, rst                    clock (rising edge), async active-low reset
//   InstrD, PCPlus4D            instruction and its PC+4 from IF/ID
//   RegWriteW, WriteRegW,
//   ResultW                     writeback port into the register file
//   ForwardAD, ForwardBD,
//   ALUOutM                     select ALUOutM for branch compare operand A/B
//   RD1D, RD2D                  register reads of Rs/Rt (never forwarded)
//   SignImmD                    sign-extended InstrD[15:0]
//   RsD, RtD, RdD               register specifiers
//   RegWriteD .. JumpD,
//   ALUControlD                 decoded controls
//   PCSrcD, PCBranchD, PCJumpD  branch taken, branch target, jump target
module decode_stage (
   input  logic        CLK,
   input  logic        rst,
   input  logic [31:0] InstrD,
   input  logic [31:0] PCPlus4D,
   input  logic        RegWriteW,
   input  logic [4:0]  WriteRegW,
   input  logic [31:0] ResultW,
   input  logic        ForwardAD,
   input  logic        ForwardBD,
   input  logic [31:0] ALUOutM,
   output logic [31:0] RD1D,
   output logic [31:0] RD2D,
   output logic [31:0] SignImmD,
   output logic [4:0]  RsD,
   output logic [4:0]  RtD,
   output logic [4:0]  RdD,
   output logic        RegWriteD,
   output logic        MemtoRegD,
   output logic        MemWriteD,
   output logic        ALUSrcD,
   output logic        RegDstD,
   output logic        BranchD,
   output logic        JumpD,
   output logic [2:0]  ALUControlD,
   output logic        PCSrcD,
   output logic [31:0] PCBranchD,
   output logic [31:0] PCJumpD
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   logic [31:0] regs [32];
   logic        wr_en;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [31:0] cmp_a;
   logic [31:0] cmp_b;

   assign opcode = InstrD[31:26];
   assign funct  = InstrD[5:0];
   assign RsD    = InstrD[25:21];
   assign RtD    = InstrD[20:16];
   assign RdD    = InstrD[15:11];

   // Writes to r0 are dropped so it stays hardwired to zero; writes while
   // reset is held are ignored.
   assign wr_en = RegWriteW && (WriteRegW != 5'd0);

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[WriteRegW] <= ResultW;
      end
   end

   // Write-through: a same-cycle writeback to the addressed register is
   // visible on the read port before the edge. Suppressed during reset so the
   // file reads all-zero while rst is low.
   always_comb begin
      RD1D = regs[RsD];
      if (RsD == 5'd0) begin
         RD1D = '0;
      end else if (rst && wr_en && (WriteRegW == RsD)) begin
         RD1D = ResultW;
      end
   end

   always_comb begin
      RD2D = regs[RtD];
      if (RtD == 5'd0) begin
         RD2D = '0;
      end else if (rst && wr_en && (WriteRegW == RtD)) begin
         RD2D = ResultW;
      end
   end

   assign SignImmD = {{16{InstrD[15]}}, InstrD[15:0]};

   always_comb begin
      RegWriteD   = 1'b0;
      RegDstD     = 1'b0;
      ALUSrcD     = 1'b0;
      BranchD     = 1'b0;
      MemWriteD   = 1'b0;
      MemtoRegD   = 1'b0;
      JumpD       = 1'b0;
      ALUControlD = 3'b000;
      case (opcode)
         OP_RTYPE: begin
            RegDstD   = 1'b1;
            RegWriteD = 1'b1;
            case (funct)
               FN_ADD:  ALUControlD = 3'b010;
               FN_SUB:  ALUControlD = 3'b110;
               FN_AND:  ALUControlD = 3'b000;
               FN_OR:   ALUControlD = 3'b001;
               FN_SLT:  ALUControlD = 3'b111;
               // unsupported funct must not corrupt the register file
               default: RegWriteD   = 1'b0;
            endcase
         end
         OP_LW: begin
            RegWriteD   = 1'b1;
            ALUSrcD     = 1'b1;
            MemtoRegD   = 1'b1;
            ALUControlD = 3'b010;
         end
         OP_SW: begin
            ALUSrcD     = 1'b1;
            MemWriteD   = 1'b1;
            ALUControlD = 3'b010;
         end
         OP_BEQ: begin
            BranchD     = 1'b1;
            ALUControlD = 3'b110;
         end
         OP_ADDI: begin
            RegWriteD   = 1'b1;
            ALUSrcD     = 1'b1;
            ALUControlD = 3'b010;
         end
         OP_J: begin
            JumpD = 1'b1;
         end
         default: ;
      endcase
   end

   // Forwarding affects only the early branch comparator, not RD1D/RD2D.
   assign cmp_a     = ForwardAD ? ALUOutM : RD1D;
   assign cmp_b     = ForwardBD ? ALUOutM : RD2D;
   assign PCSrcD    = BranchD && (cmp_a == cmp_b);
   assign PCBranchD = PCPlus4D + {SignImmD[29:0], 2'b00};
   assign PCJumpD   = {PCPlus4D[31:28], InstrD[25:0], 2'b00};

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage -- directed self-checking bench for decode_stage.
// Register-file behaviour, write-through, reset, decode table, branch
// compare with forwarding and target generation, using hand-computed vectors.
module tb_decode_stage;

   logic        CLK;
   logic        rst;
   logic [31:0] InstrD;
   logic [31:0] PCPlus4D;
   logic        RegWriteW;
   logic [4:0]  WriteRegW;
   logic [31:0] ResultW;
   logic        ForwardAD;
   logic        ForwardBD;
   logic [31:0] ALUOutM;
   logic [31:0] RD1D;
   logic [31:0] RD2D;
   logic [31:0] SignImmD;
   logic [4:0]  RsD;
   logic [4:0]  RtD;
   logic [4:0]  RdD;
   logic        RegWriteD;
   logic        MemtoRegD;
   logic        MemWriteD;
   logic        ALUSrcD;
   logic        RegDstD;
   logic        BranchD;
   logic        JumpD;
   logic [2:0]  ALUControlD;
   logic        PCSrcD;
   logic [31:0] PCBranchD;
   logic [31:0] PCJumpD;

   int passed = 0;
   int total  = 0;

   // {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, Jump, ALUControl}
   logic [9:0] ctl;
   assign ctl = {RegWriteD, RegDstD, ALUSrcD, BranchD, MemWriteD, MemtoRegD,
                 JumpD, ALUControlD};

   decode_stage dut (
      .CLK(CLK), .rst(rst), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
      .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ALUOutM(ALUOutM),
      .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
      .RsD(RsD), .RtD(RtD), .RdD(RdD),
      .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
      .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .BranchD(BranchD), .JumpD(JumpD),
      .ALUControlD(ALUControlD), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
      .PCJumpD(PCJumpD)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge CLK);
      RegWriteW = 1'b1;
      WriteRegW = a;
      ResultW   = d;
      @(posedge CLK);
      #1;
      RegWriteW = 1'b0;
      #1;
   endtask

   // Reads register r on the Rs port of an otherwise-zero instruction.
   task automatic read_rs(input logic [4:0] r, input string tag,
                          input logic [31:0] exp);
      InstrD = {6'b000000, r, 21'd0};
      #1;
      check(tag, RD1D, exp);
   endtask

   initial begin
      rst       = 1'b0;
      InstrD    = '0;
      PCPlus4D  = '0;
      RegWriteW = 1'b0;
      WriteRegW = '0;
      ResultW   = '0;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
      ALUOutM   = '0;
      #12;

      // Reset-state outputs with InstrD=0: only RegDstD set.
      check("rst_ctl", {22'd0, ctl}, {22'd0, 10'b01_0000_0000});
      check("rst_signimm", SignImmD, 32'h0);
      check("rst_pcsrc", {31'd0, PCSrcD}, 32'd0);
      check("rst_pcbranch", PCBranchD, 32'h0);

      // Write attempt while reset held is ignored.
      @(negedge CLK);
      RegWriteW = 1'b1; WriteRegW = 5'd9; ResultW = 32'hCAFEF00D;
      @(posedge CLK); #1;
      RegWriteW = 1'b0;
      @(negedge CLK);
      rst = 1'b1;
      #1;

      for (int i = 0; i < 32; i++) begin
         InstrD = {6'b000000, i[4:0], i[4:0], 16'd0};
         #1;
         check($sformatf("rst_rd1_r%0d", i), RD1D, 32'h0);
         check($sformatf("rst_rd2_r%0d", i), RD2D, 32'h0);
      end

      // add $3,$5,$5 after writing R5.
      wr(5'd5, 32'h12345678);
      InstrD = 32'h00A51820;
      #1;
      check("add_rd1", RD1D, 32'h12345678);
      check("add_rd2", RD2D, 32'h12345678);
      check("add_ctl", {22'd0, ctl}, {22'd0, 10'b11_0000_0010});
      check("add_rs", {27'd0, RsD}, 32'd5);
      check("add_rt", {27'd0, RtD}, 32'd5);
      check("add_rd", {27'd0, RdD}, 32'd3);

      // Other R-type functs; unknown funct drops RegWrite.
      InstrD = 32'h00A51822; #1;
      check("sub_ctl", {22'd0, ctl}, {22'd0, 10'b11_0000_0110});
      InstrD = 32'h00A51824; #1;
      check("and_ctl", {22'd0, ctl}, {22'd0, 10'b11_0000_0000});
      InstrD = 32'h00A51825; #1;
      check("or_ctl", {22'd0, ctl}, {22'd0, 10'b11_0000_0001});
      InstrD = 32'h00A5182A; #1;
      check("slt_ctl", {22'd0, ctl}, {22'd0, 10'b11_0000_0111});
      InstrD = 32'h00A51821; #1;
      check("badfn_ctl", {22'd0, ctl}, {22'd0, 10'b01_0000_0000});

      // I-type decode and sign extension.
      InstrD = 32'h8CA21234; #1;
      check("lw_ctl", {22'd0, ctl}, {22'd0, 10'b10_1001_0010});
      check("lw_imm", SignImmD, 32'h00001234);
      InstrD = 32'hACA28000; #1;
      check("sw_ctl", {22'd0, ctl}, {22'd0, 10'b00_1010_0010});
      check("sw_imm", SignImmD, 32'hFFFF8000);
      InstrD = 32'h20A2FFFE; #1;
      check("addi_ctl", {22'd0, ctl}, {22'd0, 10'b10_1000_0010});

      // Write to R0 is discarded, including during the write cycle itself.
      @(negedge CLK);
      RegWriteW = 1'b1; WriteRegW = 5'd0; ResultW = 32'hFFFFFFFF;
      InstrD = 32'h0;
      #1;
      check("r0_wt", RD1D, 32'h0);
      @(posedge CLK); #1;
      RegWriteW = 1'b0;
      read_rs(5'd0, "r0_after", 32'h0);

      // Write-through: R7 visible before the edge, then stored.
      @(negedge CLK);
      RegWriteW = 1'b1; WriteRegW = 5'd7; ResultW = 32'hA5A5A5A5;
      InstrD = 32'h00E00000;
      #1;
      check("wt_r7", RD1D, 32'hA5A5A5A5);
      check("wt_r7_rt", RD2D, 32'h0);
      @(posedge CLK); #1;
      RegWriteW = 1'b0;
      read_rs(5'd7, "r7_stored", 32'hA5A5A5A5);

      // Reset asserted mid-write: write cancelled, file cleared.
      @(negedge CLK);
      RegWriteW = 1'b1; WriteRegW = 5'd10; ResultW = 32'h0000DEAD;
      #2;
      rst = 1'b0;
      #1;
      read_rs(5'd5, "async_clr_r5", 32'h0);
      @(posedge CLK); #1;
      RegWriteW = 1'b0;
      @(negedge CLK);
      rst = 1'b1;
      read_rs(5'd10, "midwr_r10", 32'h0);
      read_rs(5'd7, "rst_r7", 32'h0);

      // beq $1,$2,-1 with R1=R2=4.
      wr(5'd1, 32'd4);
      wr(5'd2, 32'd4);
      InstrD   = 32'h1022FFFF;
      PCPlus4D = 32'h00000100;
      #1;
      check("beq_ctl", {22'd0, ctl}, {22'd0, 10'b00_0100_0110});
      check("beq_pcsrc", {31'd0, PCSrcD}, 32'd1);
      check("beq_target", PCBranchD, 32'h000000FC);
      ForwardAD = 1'b1; ALUOutM = 32'd5;
      #1;
      check("beq_fwda_pcsrc", {31'd0, PCSrcD}, 32'd0);
      check("beq_fwda_rd1", RD1D, 32'd4);
      ForwardBD = 1'b1;
      #1;
      check("beq_fwdab_pcsrc", {31'd0, PCSrcD}, 32'd1);
      ForwardAD = 1'b0;
      #1;
      check("beq_fwdb_pcsrc", {31'd0, PCSrcD}, 32'd0);
      check("beq_fwdb_rd2", RD2D, 32'd4);
      ForwardBD = 1'b0;
      InstrD   = 32'h10220010;
      #1;
      check("beq_fwd_target", PCBranchD, 32'h00000140);
      // Non-branch with equal operands must not redirect.
      InstrD = 32'h00221820;
      #1;
      check("add_eq_pcsrc", {31'd0, PCSrcD}, 32'd0);

      // Jump and unknown opcode.
      InstrD   = 32'h08000010;
      PCPlus4D = 32'h40000004;
      #1;
      check("j_ctl", {22'd0, ctl}, {22'd0, 10'b00_0000_1000});
      check("j_target", PCJumpD, 32'h40000040);
      InstrD = 32'hFC000000;
      #1;
      check("badop_ctl", {22'd0, ctl}, {22'd0, 10'b00_0000_0000});
      check("badop_pcsrc", {31'd0, PCSrcD}, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
